// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared types and constants for the instruction decoder
package id_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_EXT   = 2'd3
    } id_state_e;

    // Opcode class prefixes, matched against the top bits of ir
    localparam logic       OPC_LDI = 1'b0;
    localparam logic [1:0] OPC_MOV = 2'b10;
    localparam logic [2:0] OPC_ALU = 3'b110;
    localparam logic [3:0] OPC_JMP = 4'b1110;
    localparam logic [3:0] OPC_JNZ = 4'b1111;

    // Destination indices as encoded in the instruction
    localparam logic [2:0] DST_X0 = 3'd0;
    localparam logic [2:0] DST_X1 = 3'd1;
    localparam logic [2:0] DST_Y0 = 3'd2;
    localparam logic [2:0] DST_Y1 = 3'd3;
    localparam logic [2:0] DST_O  = 3'd4;
    localparam logic [2:0] DST_M  = 3'd5;
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    localparam logic [3:0] SRC_IREG  = 4'd4;
    localparam logic [3:0] SRC_IMM   = 4'd8;
    localparam logic [3:0] SRC_SELF  = 4'd9;
    localparam logic [3:0] SRC_RESET = 4'd10;

    localparam logic [7:0] LDL_PREFIX = 8'hC8;

    // Destination index to reg_en bit: index 4 is the output register at bit 8
    function automatic logic [3:0] dest_bit(input logic [2:0] d);
        return (d == DST_O) ? 4'd8 : {1'b0, d};
    endfunction

endpackage

// File: rtl/instr_decode_pipe_field_decode.sv
// rtl/instr_decode_pipe_field_decode.sv - combinational field decode of the instruction register
module id_field_decode
    import id_pkg::*;
(
    input  logic [7:0] ir,
    output logic [8:0] reg_en,
    output logic [3:0] source_sel,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       jmp,
    output logic       jmp_nz
);

    logic [2:0] d;
    logic [2:0] s;
    logic       has_d;

    // Classify the opcode and derive destination enables and source select
    always_comb begin
        reg_en     = '0;
        source_sel = SRC_IMM;
        i_sel      = 1'b1;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        d          = ir[6:4];
        s          = ir[2:0];
        has_d      = 1'b0;
        if (ir[7] == OPC_LDI) begin
            d          = ir[6:4];
            has_d      = 1'b1;
            source_sel = SRC_IMM;
        end else if (ir[7:6] == OPC_MOV) begin
            d     = ir[5:3];
            has_d = 1'b1;
            if (s == DST_O)
                source_sel = SRC_IREG;
            else if (s == d)
                source_sel = SRC_SELF;
            else
                source_sel = {1'b0, s};
            // Reading dm goes through the index register
            if (s == DST_DM)
                reg_en[6] = 1'b1;
        end else if (ir[7:5] == OPC_ALU) begin
            reg_en[4]  = 1'b1;
            x_sel      = ir[4];
            y_sel      = ir[3];
            source_sel = {1'b0, ir[2:0]};
        end else begin
            jmp        = (ir[7:4] == OPC_JMP);
            jmp_nz     = (ir[7:4] == OPC_JNZ);
            source_sel = {1'b0, ir[2:0]};
        end
        if (has_d) begin
            reg_en[dest_bit(d)] = 1'b1;
            if (d == DST_DM)
                reg_en[6] = 1'b1;
            if (d == DST_I)
                i_sel = 1'b0;
        end
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - fetch handshake, jump squash FSM and decode gating (option: ID_LONG_IMM_EN)
module instr_decode_pipe
    import id_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              jump_taken,
    output logic [7:0]        ir,
    output logic [3:0]        ir_nibble,
    output logic [DATA_W-1:0] imm,
    output logic              slot_valid,
    output logic [8:0]        reg_en,
    output logic [3:0]        source_sel,
    output logic              i_sel,
    output logic              x_sel,
    output logic              y_sel,
    output logic              jmp,
    output logic              jmp_nz
);

    localparam logic [1:0] FS_CNT = 2'(FLUSH_SLOTS);

    id_state_e         state_q;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] imm_q;
    logic [1:0]        cnt_q;
    logic              live_q;
    logic              long_q;

    logic [8:0] dec_reg_en;
    logic [3:0] dec_src;
    logic       dec_i, dec_x, dec_y, dec_jmp, dec_jnz;
    logic       accept, exec, jump_res, is_prefix;

    id_field_decode u_field (
        .ir         (ir_q),
        .reg_en     (dec_reg_en),
        .source_sel (dec_src),
        .i_sel      (dec_i),
        .x_sel      (dec_x),
        .y_sel      (dec_y),
        .jmp        (dec_jmp),
        .jmp_nz     (dec_jnz)
    );

`ifdef ID_LONG_IMM_EN
    assign is_prefix = (instr_in == LDL_PREFIX);
`else
    assign is_prefix = 1'b0;
`endif

    assign instr_ready = (state_q != ST_INIT) && !stall;
    assign accept      = instr_valid && instr_ready;
    assign exec        = (state_q != ST_INIT) && live_q && !stall;
    assign jump_res    = exec && !long_q && (dec_jmp || dec_jnz) && jump_taken && (FLUSH_SLOTS > 0);
    assign slot_valid  = (state_q != ST_INIT) && live_q;
    assign ir          = ir_q;
    assign ir_nibble   = ir_q[3:0];

    // Slot sequencing: fetch, squash window after taken jumps, long-immediate capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ir_q    <= 8'h00;
            imm_q   <= '0;
            cnt_q   <= 2'd0;
            live_q  <= 1'b0;
            long_q  <= 1'b0;
        end else if (state_q == ST_INIT) begin
            state_q <= ST_RUN;
        end else if (!stall) begin
            live_q <= 1'b0;
            long_q <= 1'b0;
            if (accept) begin
                if (state_q == ST_EXT) begin
                    imm_q   <= instr_in[DATA_W-1:0];
                    live_q  <= 1'b1;
                    long_q  <= 1'b1;
                    state_q <= ST_RUN;
                end else begin
                    ir_q <= instr_in;
                    if (jump_res) begin
                        // The byte fetched alongside the jump slot is the first one squashed
                        cnt_q   <= FS_CNT - 2'd1;
                        state_q <= (FLUSH_SLOTS == 1) ? ST_RUN : ST_FLUSH;
                    end else if (state_q == ST_FLUSH) begin
                        cnt_q <= cnt_q - 2'd1;
                        if (cnt_q == 2'd1)
                            state_q <= ST_RUN;
                    end else if (is_prefix) begin
                        state_q <= ST_EXT;
                    end else begin
                        live_q <= 1'b1;
                    end
                end
            end else if (jump_res) begin
                cnt_q   <= FS_CNT;
                state_q <= ST_FLUSH;
            end
        end
    end

    // Output gating: reset pattern in INIT, bubbles and stalls suppress enables
    always_comb begin
        reg_en     = '0;
        source_sel = dec_src;
        i_sel      = dec_i;
        x_sel      = dec_x;
        y_sel      = dec_y;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        imm        = '0;
        imm[3:0]   = ir_q[3:0];
        if (state_q == ST_INIT) begin
            reg_en     = 9'h1FF;
            source_sel = SRC_RESET;
            i_sel      = 1'b0;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
        end else if (long_q) begin
            reg_en     = exec ? 9'h020 : 9'h000;
            source_sel = SRC_IMM;
            i_sel      = 1'b1;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
            imm        = imm_q;
        end else if (exec) begin
            reg_en = dec_reg_en;
            jmp    = dec_jmp;
            jmp_nz = dec_jnz;
        end
    end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - directed and random checks of instr_decode_pipe against a slot model
module tb_instr_decode_pipe;

    localparam int DW = 8;
    localparam int FS = 2;
`ifdef ID_LONG_IMM_EN
    localparam bit LDL = 1'b1;
`else
    localparam bit LDL = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [7:0]    instr_in;
    logic          instr_valid;
    logic          instr_ready;
    logic          stall;
    logic          jump_taken;
    logic [7:0]    ir;
    logic [3:0]    ir_nibble;
    logic [DW-1:0] imm;
    logic          slot_valid;
    logic [8:0]    reg_en;
    logic [3:0]    source_sel;
    logic          i_sel, x_sel, y_sel, jmp, jmp_nz;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what the current slot holds, and fetch-side bookkeeping
    bit         m_init;
    bit         m_live;
    bit         m_long;
    logic [7:0] m_byte;
    logic [7:0] m_lval;
    int         m_squash;
    bit         m_pend;

    instr_decode_pipe #(.DATA_W(DW), .FLUSH_SLOTS(FS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .jump_taken  (jump_taken),
        .ir          (ir),
        .ir_nibble   (ir_nibble),
        .imm         (imm),
        .slot_valid  (slot_valid),
        .reg_en      (reg_en),
        .source_sel  (source_sel),
        .i_sel       (i_sel),
        .x_sel       (x_sel),
        .y_sel       (y_sel),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction meaning taken straight from the opcode table
    function automatic void ref_decode(input logic [7:0] b, output logic [8:0] re,
                                       output logic [3:0] src, output logic is_,
                                       output logic xs, output logic ys,
                                       output logic j, output logic jn);
        logic [2:0] d;
        logic [2:0] s;
        bit         hasd;
        re = '0; src = 4'd0; is_ = 1'b1; xs = 1'b0; ys = 1'b0; j = 1'b0; jn = 1'b0;
        d = 3'd0; s = b[2:0]; hasd = 1'b0;
        if (b < 8'h80) begin
            d = b[6:4]; hasd = 1'b1; src = 4'd8;
        end else if (b < 8'hC0) begin
            d = b[5:3]; hasd = 1'b1;
            if (s == 3'd4) src = 4'd4;
            else if (s == d) src = 4'd9;
            else src = {1'b0, s};
            if (s == 3'd7) re[6] = 1'b1;
        end else if (b < 8'hE0) begin
            re[4] = 1'b1; xs = b[4]; ys = b[3]; src = {1'b0, s};
        end else begin
            j = (b < 8'hF0); jn = (b >= 8'hF0); src = {1'b0, s};
        end
        if (hasd) begin
            if (d == 3'd4) re[8] = 1'b1;
            else re[d] = 1'b1;
            if (d == 3'd7) re[6] = 1'b1;
            if (d == 3'd6) is_ = 1'b0;
        end
    endfunction

    task automatic step(input logic rn, input logic v, input logic [7:0] b,
                        input logic st, input logic jt);
        logic [8:0] re;
        logic [3:0] src;
        logic       is_, xs, ys, j, jn, ex;
        logic [7:0] eimm;
        reset_n = rn; instr_valid = v; instr_in = b; stall = st; jump_taken = jt;
        if (!rn) begin
            m_init = 1'b1; m_live = 1'b0; m_long = 1'b0; m_byte = 8'h00;
            m_lval = 8'h00; m_squash = 0; m_pend = 1'b0;
        end
        #1;
        ex = m_live && !st && !m_init;
        ref_decode(m_byte, re, src, is_, xs, ys, j, jn);
        eimm = {4'h0, m_byte[3:0]};
        if (m_init) begin
            re = 9'h1FF; src = 4'd10; is_ = 1'b0; xs = 1'b0; ys = 1'b0; j = 1'b0; jn = 1'b0;
        end else if (m_long) begin
            re = 9'h020; src = 4'd8; is_ = 1'b1; xs = 1'b0; ys = 1'b0; j = 1'b0; jn = 1'b0;
            eimm = m_lval;
        end
        if (!m_init && !ex) begin
            re = 9'h000; j = 1'b0; jn = 1'b0;
        end
        chk("instr_ready", 32'(instr_ready), 32'(!m_init && !st));
        chk("slot_valid", 32'(slot_valid), 32'(m_live && !m_init));
        chk("ir", 32'(ir), 32'(m_byte));
        chk("ir_nibble", 32'(ir_nibble), 32'(m_byte[3:0]));
        chk("reg_en", 32'(reg_en), 32'(re));
        chk("jmp", 32'(jmp), 32'(j));
        chk("jmp_nz", 32'(jmp_nz), 32'(jn));
        if (ex || m_init) begin
            chk("source_sel", 32'(source_sel), 32'(src));
            chk("i_sel", 32'(i_sel), 32'(is_));
            chk("x_sel", 32'(x_sel), 32'(xs));
            chk("y_sel", 32'(y_sel), 32'(ys));
        end
        if (ex && (m_long || !m_byte[7]))
            chk("imm", 32'(imm), 32'(eimm));
        @(posedge clk);
        if (rn) begin
            if (m_init) begin
                m_init = 1'b0;
            end else if (!st) begin
                if (ex && !m_long && m_byte[7:5] == 3'b111 && jt && FS > 0)
                    m_squash = FS;
                m_long = 1'b0;
                if (!v) begin
                    m_live = 1'b0;
                end else if (m_pend) begin
                    m_pend = 1'b0; m_live = 1'b1; m_long = 1'b1; m_lval = b;
                end else begin
                    m_byte = b;
                    if (m_squash > 0) begin
                        m_squash--; m_live = 1'b0;
                    end else if (LDL && b == 8'hC8) begin
                        m_pend = 1'b1; m_live = 1'b0;
                    end else begin
                        m_live = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        reset_n = 1'b0; instr_valid = 1'b0; instr_in = 8'h00; stall = 1'b0; jump_taken = 1'b0;
        @(posedge clk);
        #1;
        // reset, INIT cycle, then load-immediate 25
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h25, 0, 0);
        step(1, 1, 8'h25, 0, 0);
        step(1, 1, 8'h25, 0, 0);
        // moves, jump_taken outside a jump slot is ignored
        step(1, 1, 8'hBE, 0, 1);
        step(1, 1, 8'h9B, 0, 1);
        step(1, 1, 8'hA4, 0, 1);
        step(1, 1, 8'hB8, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        // taken jump with an idle jump-slot cycle, two squashed bytes
        step(1, 1, 8'hE3, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        step(1, 1, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h13, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // back-to-back stream with jump_taken held high
        step(1, 1, 8'hF5, 0, 1);
        step(1, 1, 8'h01, 0, 1);
        step(1, 1, 8'h02, 0, 1);
        step(1, 1, 8'h13, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        // stall on an ALU slot
        step(1, 1, 8'hD9, 0, 0);
        step(1, 1, 8'h55, 1, 0);
        step(1, 1, 8'h55, 1, 0);
        step(1, 1, 8'h55, 1, 0);
        step(1, 0, 8'h55, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // stalled jump slot, stall inside the squash window
        step(1, 1, 8'hE1, 0, 0);
        step(1, 1, 8'h66, 1, 1);
        step(1, 1, 8'h66, 1, 1);
        step(1, 1, 8'h66, 0, 1);
        step(1, 1, 8'h77, 1, 0);
        step(1, 1, 8'h77, 0, 0);
        step(1, 1, 8'h6A, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // reset in the middle of a squash window
        step(1, 1, 8'hE2, 0, 0);
        step(1, 1, 8'h01, 0, 1);
        step(0, 1, 8'h02, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h31, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // C8 then A7: long-immediate pair or ALU plus move depending on build
        step(1, 1, 8'hC8, 0, 0);
        step(1, 1, 8'hA7, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // reset between prefix and payload
        step(1, 1, 8'hC8, 0, 0);
        step(0, 1, 8'hA7, 0, 0);
        step(1, 1, 8'hA7, 0, 0);
        step(1, 1, 8'hA7, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // prefix inside a squash window must not open a long immediate
        step(1, 1, 8'hE0, 0, 0);
        step(1, 1, 8'hC8, 0, 1);
        step(1, 1, 8'hC8, 0, 0);
        step(1, 1, 8'h25, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            logic       rn;
            logic [7:0] b;
            rn = ($urandom_range(63) != 0);
            b  = ($urandom_range(7) == 0) ? 8'hC8 : 8'($urandom);
            step(rn, $urandom_range(9) < 7, b, $urandom_range(4) == 0, $urandom_range(1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Parametrised instruction decoder for the nanoprocessor core. It sits between the program-memory fetch stage and the datapath. Byte fetch uses a valid/ready handshake; the instruction register honours datapath stalls. After a taken jump it squashes a configurable number of already-fetched bytes. It can optionally decode a two-byte long-immediate load.

## Interface
Parameters:
- DATA_W, 4: datapath width; immediate output width; legal 4..8
- FLUSH_SLOTS, 1: fetched bytes squashed after a taken jump; legal 0..3

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instr_in  in  8  fetched instruction byte
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  decoder accepts instr_in this cycle
- stall  in  1  datapath stall; holds the current slot
- jump_taken  in  1  PC unit resolves the current jmp/jmp_nz as taken
- ir  out  8  instruction register
- ir_nibble  out  4  ir[3:0]
- imm  out  DATA_W  immediate operand
- slot_valid  out  1  the current ir is a live, executing instruction
- reg_en  out  9  [8]o_reg [7]dm [6]i [5]m [4]r [3]y1 [2]y0 [1]x1 [0]x0
- source_sel  out  4  datapath source mux select
- i_sel, x_sel, y_sel  out  1 each  operand selects
- jmp, jmp_nz  out  1 each  instruction-type flags

## Operation
- FSM states: INIT, RUN, FLUSH, EXT.
- INIT is held while reset_n=0 and for exactly one cycle after release, then the FSM moves to RUN.
  - Outputs in INIT: reg_en=9'h1FF, source_sel=10, i_sel/x_sel/y_sel=0, jmp/jmp_nz=0, slot_valid=0, instr_ready=0.
  - Register reset values: ir=8'h00, imm register=0, flush counter=0.
- instr_ready = (state!=INIT) && !stall.
- A byte is accepted when instr_valid && instr_ready. The accepted byte loads ir (or the imm register in EXT) at that edge.
- No accepted byte means the next slot is a bubble: slot_valid=0, reg_en=0, jmp=jmp_nz=0.
- stall=1 holds ir and the slot. reg_en, jmp and jmp_nz are forced to 0 while stalled. The held slot executes in the first cycle with stall=0.
- Decode applies when slot_valid=1 and stall=0. Destination index d maps to reg_en bit d, except d=4, which maps to bit 8.
  - ir[7]=0, load immediate: d=ir[6:4]; source_sel=8; imm=zero-extended ir[3:0].
  - ir[7:6]=10, move: d=ir[5:3], s=ir[2:0]. source_sel is 4 if s=4; otherwise 9 if s=d; otherwise s.
  - ir[7:5]=110, ALU: reg_en[4]=1; x_sel=ir[4]; y_sel=ir[3]; source_sel=ir[2:0].
  - ir[7:4]=1110: jmp=1. ir[7:4]=1111: jmp_nz=1. For both, source_sel=ir[2:0] and reg_en=0.
  - reg_en[6] (i) is also set when d=7, or when a move has s=7.
  - i_sel=0 when d=6; otherwise 1. x_sel and y_sel are 0 outside ALU instructions.
- Jump resolution:
  - jump_taken is sampled only in a valid, unstalled jmp/jmp_nz slot.
  - If jump_taken=1 and FLUSH_SLOTS>0: the FSM moves to FLUSH and the counter loads FLUSH_SLOTS.
  - In FLUSH, each accepted byte decrements the counter and is decoded as a bubble. The FSM returns to RUN when the counter reaches 0.
  - jump_taken outside a valid jump slot is ignored.

## Timing
- Byte accepted at edge n: its decode is valid during cycle n+1, registered ir to combinational outputs.
- Squash window: exactly FLUSH_SLOTS accepted bytes after the taken-jump slot. Cycles with no accepted byte do not decrement the counter.
- Stall during FLUSH freezes both the counter and the state.
- Reset asserted mid-FLUSH or mid-EXT: the FSM goes to INIT immediately, the counter clears, and any pending prefix is dropped.
- A jump slot that is stalled does not resolve until stall=0.

## Configuration
- ID_LONG_IMM_EN defined:
  - Byte 8'hC8 is the LDL prefix. Its slot is a bubble, and the FSM moves to EXT.
  - The next accepted byte loads the imm register with byte[DATA_W-1:0].
  - That slot is valid with reg_en[5]=1 (m), source_sel=8, imm=imm register. The FSM then returns to RUN.
  - A prefix squashed by FLUSH does not enter EXT.
- ID_LONG_IMM_EN undefined: 8'hC8 decodes as an ordinary ALU instruction, and the EXT state is unreachable.

## Structure
- Package id_pkg:
  - State enum.
  - Opcode class constants.
  - Destination index constants: X0..DM.
  - SRC_IMM=8, SRC_SELF=9, SRC_RESET=10, SRC_IREG=4.
  - LDL_PREFIX=8'hC8.
- Sub-module id_field_decode: purely combinational decode from ir to reg_en, source_sel and the selects. The top level holds the FSM, ir, the imm register, the flush counter, the handshake and output gating.

## Test plan
- Reset release, then instr_valid=1 with 8'h25: one cycle of reg_en=1FF and source_sel=10; then reg_en=004 (y0), source_sel=8, imm=5.
- Move 8'hBE (d=7, s=6): reg_en=0C0, source_sel=6. Then 8'h9B (d=3, s=3): reg_en=008, source_sel=9.
- FLUSH_SLOTS=2; stream E3, 01, 02, 13 with jump_taken=1 on E3: 01 and 02 are bubbles; 13 gives reg_en=002.
- stall=1 for 3 cycles on 8'hD9: ir is held, reg_en=0 and instr_ready=0; when stall drops, reg_en=010, x_sel=1, y_sel=1 for one cycle.
- With ID_LONG_IMM_EN and DATA_W=8: C8 then A7 gives a bubble, then reg_en=020, imm=A7. Reset asserted between the two bytes returns the FSM to INIT.
